// File: rtl/clk_gate_ctrl.sv
// clk_gate_ctrl: per-channel clock-gating controller. It runs an idle timer, an off_req/off_ack
//   drain handshake and a wake-up settle counter, and drives the enables of NCH gating cells.
// Latency: the outputs are flops decoded from the registered state. They change one edge after the
//   state changes. An active cycle at edge k gives gate_en after k+1 and ready after k+1+WAKE_CYC.
// Backpressure: a channel stays in DRAIN with off_req high until the client returns off_ack.
//   Any activity during DRAIN aborts the drain.
// Ports:
//   clk_in, rst_n          always-on clock, async active-low reset
//   idle_thresh[IDLE_W]    idle cycles before gating (0 = never gate), shared
//   busy/wake_req/off_ack  per-channel activity, wake request, drain acknowledge
//   gate_en/ready/off_req/gated  per-channel registered status/enables
//   bypass                 only with CLK_GATE_CTRL_BYPASS_EN: force every channel running
module clk_gate_ctrl #(
  parameter int NCH      = 4,
  parameter int IDLE_W   = 8,
  parameter int WAKE_CYC = 2
) (
  input  logic              clk_in,
  input  logic              rst_n,
`ifdef CLK_GATE_CTRL_BYPASS_EN
  input  logic              bypass,
`endif
  input  logic [IDLE_W-1:0] idle_thresh,
  input  logic [NCH-1:0]    busy,
  input  logic [NCH-1:0]    wake_req,
  input  logic [NCH-1:0]    off_ack,
  output logic [NCH-1:0]    gate_en,
  output logic [NCH-1:0]    ready,
  output logic [NCH-1:0]    off_req,
  output logic [NCH-1:0]    gated
);

  localparam int WK_W = (WAKE_CYC > 1) ? $clog2(WAKE_CYC) : 1;
  localparam logic [WK_W-1:0] WK_LAST = WK_W'((WAKE_CYC > 0) ? WAKE_CYC - 1 : 0);

  typedef enum logic [2:0] {S_OFF, S_WAKE, S_RUN, S_COUNT, S_DRAIN} state_t;

  logic force_run;
`ifdef CLK_GATE_CTRL_BYPASS_EN
  assign force_run = bypass;
`else
  assign force_run = 1'b0;
`endif

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    state_t            state_q, state_d, out_src;
    logic [IDLE_W-1:0] cnt_q, cnt_d;
    logic [WK_W-1:0]   wcnt_q, wcnt_d;
    logic [IDLE_W:0]   cnt_inc;
    logic              active;
    logic              gate_en_q, ready_q, off_req_q, gated_q;

    assign active  = busy[i] | wake_req[i];
    // One extra bit keeps cnt+1 from wrapping when it is compared with the threshold.
    assign cnt_inc = {1'b0, cnt_q} + {{IDLE_W{1'b0}}, 1'b1};

    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      wcnt_d  = wcnt_q;
      case (state_q)
        S_OFF: begin
          if (active) begin
            state_d = (WAKE_CYC == 0) ? S_RUN : S_WAKE;
            wcnt_d  = '0;
          end
        end
        S_WAKE: begin
          // Client activity is ignored here; only the settle time matters.
          if (wcnt_q == WK_LAST) begin
            state_d = S_RUN;
            wcnt_d  = '0;
          end else begin
            wcnt_d = wcnt_q + WK_W'(1);
          end
        end
        S_RUN: begin
          cnt_d = '0;
          if (!active && (idle_thresh != '0)) begin
            if (idle_thresh == IDLE_W'(1)) begin
              state_d = S_DRAIN;
            end else begin
              state_d = S_COUNT;
              cnt_d   = IDLE_W'(1);
            end
          end
        end
        S_COUNT: begin
          // The threshold is compared live. Lowering it takes effect at once, and 0 cancels the count.
          if (active || (idle_thresh == '0)) begin
            state_d = S_RUN;
            cnt_d   = '0;
          end else if (cnt_inc >= {1'b0, idle_thresh}) begin
            state_d = S_DRAIN;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_inc[IDLE_W-1:0];
          end
        end
        S_DRAIN: begin
          // Activity takes priority over a simultaneous acknowledge.
          if (active) begin
            state_d = S_RUN;
          end else if (off_ack[i]) begin
            state_d = S_OFF;
          end
        end
        default: state_d = S_OFF;
      endcase
      if (force_run) begin
        state_d = S_RUN;
        cnt_d   = '0;
        wcnt_d  = '0;
      end
    end

    // With bypass set, the outputs are decoded as RUN directly, so they switch on the next edge.
    assign out_src = force_run ? S_RUN : state_q;

    always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
        state_q   <= S_OFF;
        cnt_q     <= '0;
        wcnt_q    <= '0;
        gate_en_q <= 1'b0;
        ready_q   <= 1'b0;
        off_req_q <= 1'b0;
        gated_q   <= 1'b1;
      end else begin
        state_q   <= state_d;
        cnt_q     <= cnt_d;
        wcnt_q    <= wcnt_d;
        gate_en_q <= (out_src != S_OFF);
        ready_q   <= (out_src == S_RUN) || (out_src == S_COUNT);
        off_req_q <= (out_src == S_DRAIN);
        gated_q   <= (out_src == S_OFF);
      end
    end

    assign gate_en[i] = gate_en_q;
    assign ready[i]   = ready_q;
    assign off_req[i] = off_req_q;
    assign gated[i]   = gated_q;
  end

endmodule

// File: tb/tb_clk_gate_ctrl.sv
// tb_clk_gate_ctrl: directed and random stimulus for clk_gate_ctrl, checked against a behavioural model.
// Latency: the model predicts outputs one edge behind its own channel state.
// Backpressure: off_ack is driven directly by the bench.
module tb_clk_gate_ctrl;
  localparam int NCH = 4, IDLE_W = 8, WAKE_CYC = 2;

  logic clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  logic              rst_n;
  logic [IDLE_W-1:0] idle_thresh;
  logic [NCH-1:0]    busy, wake_req, off_ack;
  logic [NCH-1:0]    gate_en, ready, off_req, gated;
`ifdef CLK_GATE_CTRL_BYPASS_EN
  logic bypass = 1'b0;
`endif

  clk_gate_ctrl #(.NCH(NCH), .IDLE_W(IDLE_W), .WAKE_CYC(WAKE_CYC)) dut (
    .clk_in(clk_in), .rst_n(rst_n),
`ifdef CLK_GATE_CTRL_BYPASS_EN
    .bypass(bypass),
`endif
    .idle_thresh(idle_thresh), .busy(busy), .wake_req(wake_req), .off_ack(off_ack),
    .gate_en(gate_en), .ready(ready), .off_req(off_req), .gated(gated)
  );

  int n_pass = 0, n_total = 0;

  // Behavioural model: clock on/off, settle cycles left, idle run length, drain pending.
  bit  m_on[NCH];
  int  m_settle[NCH];
  int  m_idle[NCH];
  bit  m_drain[NCH];
  logic [NCH-1:0] eg, er, eo, egd;

  task automatic model_reset();
    for (int i = 0; i < NCH; i++) begin
      m_on[i] = 0; m_settle[i] = 0; m_idle[i] = 0; m_drain[i] = 0;
    end
    eg = '0; er = '0; eo = '0; egd = '1;
  endtask

  // One clock edge: the visible outputs reflect the channel state before this edge.
  task automatic tick();
    bit act;
    @(posedge clk_in);
    for (int i = 0; i < NCH; i++) begin
      eg[i]  = m_on[i];
      er[i]  = m_on[i] && (m_settle[i] == 0) && !m_drain[i];
      eo[i]  = m_drain[i];
      egd[i] = !m_on[i];
      act = busy[i] | wake_req[i];
      if (!m_on[i]) begin
        if (act) begin m_on[i] = 1; m_settle[i] = WAKE_CYC; m_idle[i] = 0; end
      end else if (m_settle[i] > 0) begin
        m_settle[i]--;
      end else if (m_drain[i]) begin
        if (act) begin m_drain[i] = 0; m_idle[i] = 0; end
        else if (off_ack[i]) begin m_drain[i] = 0; m_on[i] = 0; m_idle[i] = 0; end
      end else begin
        if (act || idle_thresh == 0) m_idle[i] = 0;
        else begin
          m_idle[i]++;
          if (m_idle[i] >= int'(idle_thresh)) begin m_drain[i] = 1; m_idle[i] = 0; end
        end
      end
    end
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; busy = '0; wake_req = '0; off_ack = '0; idle_thresh = '0;
    model_reset();
    @(posedge clk_in); @(posedge clk_in); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    n_total++;
    if ({gate_en, ready, off_req, gated} !== {4'h0, 4'h0, 4'h0, 4'hF})
      $display("FAIL reset_values: got ge=%b rdy=%b oreq=%b gated=%b", gate_en, ready, off_req, gated);
    else n_pass++;
    for (int c = 0; c < 3; c++) begin
      tick();
      n_total++;
      if ({gate_en, ready, off_req, gated} !== {eg, er, eo, egd})
        $display("FAIL reset_idle: got %b/%b/%b/%b want %b/%b/%b/%b", gate_en, ready, off_req, gated, eg, er, eo, egd);
      else n_pass++;
    end
  endtask

  task automatic test_wake();
    idle_thresh = 0;
    wake_req = 4'b0001;
    tick();
    wake_req = '0;
    for (int c = 1; c <= 4; c++) begin
      n_total++;
      if ({gate_en, ready, off_req, gated} !== {eg, er, eo, egd})
        $display("FAIL wake_model c=%0d: got %b/%b/%b/%b want %b/%b/%b/%b", c, gate_en, ready, off_req, gated, eg, er, eo, egd);
      else n_pass++;
      // After c edges following the sampled request: gate_en from c=1, ready from c=3.
      n_total++;
      if (gate_en[0] !== (c >= 2) || ready[0] !== (c >= 4) || gated[3:1] !== 3'b111)
        $display("FAIL wake_timing c=%0d: ge0=%b rdy0=%b gated=%b", c - 1, gate_en[0], ready[0], gated);
      else n_pass++;
      tick();
    end
  endtask

  task automatic test_gate();
    idle_thresh = 5;
    for (int c = 0; c < 6; c++) begin
      tick();
      n_total++;
      if (off_req[0] !== (c == 5) || {gate_en, ready, off_req, gated} !== {eg, er, eo, egd})
        $display("FAIL gate_idle c=%0d: oreq=%b want %b (model oreq %b)", c, off_req[0], (c == 5), eo);
      else n_pass++;
    end
    off_ack = 4'b0001;
    tick();
    off_ack = '0;
    n_total++;
    if (gate_en[0] !== 1'b1) $display("FAIL gate_ack_early: ge0=%b want 1", gate_en[0]); else n_pass++;
    tick();
    n_total++;
    if (gate_en[0] !== 1'b0 || gated[0] !== 1'b1 || {gate_en, ready, off_req, gated} !== {eg, er, eo, egd})
      $display("FAIL gate_ack: ge0=%b gated0=%b want 0/1", gate_en[0], gated[0]);
    else n_pass++;
  endtask

  task automatic test_busy_abort();
    wake_req = 4'b0010;
    tick();
    wake_req = '0;
    repeat (5) tick();   // wake settles in 2 edges, then 3 idle edges leave cnt at 3
    busy = 4'b0010;
    tick();
    busy = '0;
    for (int c = 0; c < 6; c++) begin
      tick();
      n_total++;
      if (off_req[1] !== (c == 5) || {gate_en, ready, off_req, gated} !== {eg, er, eo, egd})
        $display("FAIL busy_abort c=%0d: oreq1=%b want %b", c, off_req[1], (c == 5));
      else n_pass++;
    end
  endtask

  task automatic test_drain_race();
    int   n;
    do_reset();
    idle_thresh = 2;
    wake_req = 4'b0100;
    tick();
    wake_req = '0;
    n = 0;
    while (off_req[2] !== 1'b1 && n < 20) begin tick(); n++; end
    n_total++;
    if (off_req[2] !== 1'b1) $display("FAIL drain_timeout: oreq2=%b want 1", off_req[2]); else n_pass++;
    busy = 4'b0100; off_ack = 4'b0100;
    tick();
    off_ack = '0;
    tick();
    n_total++;
    if (off_req[2] !== 1'b0 || gate_en[2] !== 1'b1 || {gate_en, ready, off_req, gated} !== {eg, er, eo, egd})
      $display("FAIL drain_race: oreq2=%b ge2=%b want 0/1", off_req[2], gate_en[2]);
    else n_pass++;
    busy = '0;
  endtask

  task automatic test_thresh_zero();
    bit bad;
    do_reset();
    idle_thresh = 0;
    wake_req = '1;
    tick();
    wake_req = '0;
    bad = 0;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (off_req !== '0 || {gate_en, ready, off_req, gated} !== {eg, er, eo, egd}) bad = 1;
    end
    n_total++;
    if (bad || ready !== 4'hF) $display("FAIL thresh_zero: oreq=%b rdy=%b want 0000/1111", off_req, ready);
    else n_pass++;
  endtask

  task automatic test_async_reset();
    int n;
    do_reset();
    idle_thresh = 1;
    wake_req = 4'b1000;
    tick();
    wake_req = '0;
    n = 0;
    while (off_req[3] !== 1'b1 && n < 20) begin tick(); n++; end
    n_total++;
    if (off_req[3] !== 1'b1) $display("FAIL areset_drain_timeout: oreq3=%b want 1", off_req[3]); else n_pass++;
    #3 rst_n = 1'b0;
    #1;
    n_total++;
    if ({gate_en, ready, off_req, gated} !== {4'h0, 4'h0, 4'h0, 4'hF})
      $display("FAIL async_reset: got ge=%b rdy=%b oreq=%b gated=%b", gate_en, ready, off_req, gated);
    else n_pass++;
    model_reset();
    @(posedge clk_in); #1;
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      n_total++;
      if ({gate_en, ready, off_req, gated} !== {eg, er, eo, egd})
        $display("FAIL after_reset: got %b/%b/%b/%b want %b/%b/%b/%b", gate_en, ready, off_req, gated, eg, er, eo, egd);
      else n_pass++;
    end
  endtask

  task automatic test_random();
    int errs;
    do_reset();
    errs = 0;
    for (int c = 0; c < 600; c++) begin
      if (c % 50 == 0) idle_thresh = IDLE_W'($urandom_range(0, 6));
      if ((c / 40) % 2 == 1) begin
        busy = '0;
        wake_req = '0;
      end else begin
        busy = NCH'($urandom & $urandom);
        wake_req = ($urandom_range(0, 7) == 0) ? NCH'($urandom & $urandom) : '0;
      end
      off_ack = NCH'($urandom);
      tick();
      n_total++;
      if ({gate_en, ready, off_req, gated} !== {eg, er, eo, egd}) begin
        if (errs < 10)
          $display("FAIL random c=%0d: got %b/%b/%b/%b want %b/%b/%b/%b", c, gate_en, ready, off_req, gated, eg, er, eo, egd);
        errs++;
      end else n_pass++;
    end
    busy = '0; wake_req = '0; off_ack = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_wake();
    test_gate();
    test_busy_abort();
    test_drain_race();
    test_thresh_zero();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
